dcache_stall_responder: RTL and testbench



---
 rtl/dcache_stall_responder_if.sv | 23 ++
 rtl/dcache_stall_responder.sv | 150 +++++++++++++++
 tb/tb_dcache_stall_responder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/dcache_stall_responder_if.sv
// Data-memory stall interface between the Memory stage (master) and the
// cache responder (slave).
interface dcache_stall_responder_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;

  modport master (
    output Addr, DataIn, Rd, Wr,
    input  DataOut, Done, Stall, CacheHit, err
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr,
    output DataOut, Done, Stall, CacheHit, err
  );
endinterface

// File: rtl/dcache_stall_responder.sv
// Direct-mapped cache responder over a word-addressed backing array:
// hits complete in the request cycle, misses stall MISS_LAT cycles.
module dcache_stall_responder #(
  parameter int MEM_AW   = 10,
  parameter int IDX_W    = 3,
  parameter int MISS_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  dcache_stall_responder_if.slave  bus
);

  localparam int NLINES = 1 << IDX_W;
  localparam int DEPTH  = 1 << MEM_AW;
  localparam int TAG_W  = MEM_AW - IDX_W;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [15:0]        addr_q, addr_d;
  logic [15:0]        data_q, data_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic               err_q, err_d;

  logic               valid_q [NLINES];
  logic [TAG_W-1:0]   tag_q   [NLINES];
  logic [15:0]        mem_q   [DEPTH];

  logic               req, misal, hit;
  logic [MEM_AW-1:0]  widx_live, widx_lat;
  logic [IDX_W-1:0]   idx_live, idx_lat;
  logic [TAG_W-1:0]   tag_live, tag_lat;

  logic               we;
  logic [MEM_AW-1:0]  waddr;
  logic [15:0]        wdata;
  logic               install;

  logic [15:0]        dout;
  logic               done, stall, chit;

  assign widx_live = bus.Addr[MEM_AW:1];
  assign idx_live  = bus.Addr[IDX_W:1];
  assign tag_live  = bus.Addr[MEM_AW:IDX_W+1];
  assign widx_lat  = addr_q[MEM_AW:1];
  assign idx_lat   = addr_q[IDX_W:1];
  assign tag_lat   = addr_q[MEM_AW:IDX_W+1];

  assign req   = bus.Rd | bus.Wr;
  assign misal = req & bus.Addr[0];
  assign hit   = valid_q[idx_live] & (tag_q[idx_live] == tag_live);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    install = 1'b0;
    dout    = '0;
    done    = 1'b0;
    stall   = 1'b0;
    chit    = 1'b0;
    err_d   = err_q | (bus.Rd & bus.Wr) | misal;

    unique case (state_q)
      IDLE: begin
        if (req && !misal) begin
          if (hit) begin
            done  = 1'b1;
            chit  = 1'b1;
            // Rd & Wr together is serviced as a write, so no read data.
            if (bus.Rd && !bus.Wr) dout = mem_q[widx_live];
            we    = bus.Wr;
            waddr = widx_live;
            wdata = bus.DataIn;
          end else begin
            stall   = 1'b1;
            addr_d  = bus.Addr;
            data_d  = bus.DataIn;
            rd_d    = bus.Rd;
            wr_d    = bus.Wr;
            cnt_d   = 4'(MISS_LAT - 1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!req || bus.Addr != addr_q || bus.Rd != rd_q || bus.Wr != wr_q)
          err_d = 1'b1;
        if (cnt_q != 4'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end else begin
          done    = 1'b1;
          if (rd_q && !wr_q) dout = mem_q[widx_lat];
          we      = wr_q;
          waddr   = widx_lat;
          wdata   = data_q;
          install = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < NLINES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
      end
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      if (we) mem_q[waddr] <= wdata;
      if (install) begin
        valid_q[idx_lat] <= 1'b1;
        tag_q[idx_lat]   <= tag_lat;
      end
    end
  end

  assign bus.DataOut  = dout;
  assign bus.Done     = done;
  assign bus.Stall    = stall;
  assign bus.CacheHit = chit;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_dcache_stall_responder.sv
// Directed and randomized checks of the cache responder against a
// word/line-level reference model.
module tb_dcache_stall_responder;
  localparam int MEM_AW   = 10;
  localparam int IDX_W    = 3;
  localparam int MISS_LAT = 4;
  localparam int DEPTH    = 1 << MEM_AW;
  localparam int NL       = 1 << IDX_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_stall_responder_if bus ();

  dcache_stall_responder #(
    .MEM_AW  (MEM_AW),
    .IDX_W   (IDX_W),
    .MISS_LAT(MISS_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  logic [15:0] mem_m [DEPTH];
  bit          vld_m [NL];
  int          tag_m [NL];
  bit          err_m;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 2) % DEPTH;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'h0000;
    for (int i = 0; i < NL; i++) begin
      vld_m[i] = 1'b0;
      tag_m[i] = 0;
    end
    err_m = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.Addr = 16'h0000; bus.DataIn = 16'h0000; bus.Rd = 1'b0; bus.Wr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_done",  bus.Done,     16'd0);
    chk("rst_stall", bus.Stall,    16'd0);
    chk("rst_hit",   bus.CacheHit, 16'd0);
    chk("rst_dout",  bus.DataOut,  16'd0);
    chk("rst_err",   bus.err,      16'd0);
    @(posedge clk); #1;
  endtask

  // drop_c: cycle in which Rd/Wr are released; rst_c: cycle in which rst is pulsed.
  task automatic do_req(input string tag, input logic [15:0] a, input logic [15:0] d,
                        input logic rd, input logic wr, input int drop_c, input int rst_c);
    int          w, line, tg;
    bit          hit, vio;
    logic [15:0] expd;
    w    = widx(a);
    line = w % NL;
    tg   = w / NL;
    bus.Addr = a; bus.DataIn = d; bus.Rd = rd; bus.Wr = wr;
    if (a[0]) begin
      @(negedge clk);
      chk({tag, "_mis_done"},  bus.Done,  16'd0);
      chk({tag, "_mis_stall"}, bus.Stall, 16'd0);
      chk({tag, "_mis_err"},   bus.err,   16'(err_m));
      @(posedge clk); #1;
      err_m = 1'b1;
      idle_inputs();
      return;
    end
    hit  = vld_m[line] && (tag_m[line] == tg);
    expd = (rd && !wr) ? mem_m[w] : 16'h0000;
    if (hit) begin
      @(negedge clk);
      chk({tag, "_hit_done"},  bus.Done,     16'd1);
      chk({tag, "_hit_hit"},   bus.CacheHit, 16'd1);
      chk({tag, "_hit_stall"}, bus.Stall,    16'd0);
      chk({tag, "_hit_dout"},  bus.DataOut,  expd);
      chk({tag, "_hit_err"},   bus.err,      16'(err_m));
      @(posedge clk); #1;
      if (rd && wr) err_m = 1'b1;
      if (wr) mem_m[w] = d;
      idle_inputs();
      return;
    end
    for (int c = 0; c <= MISS_LAT; c++) begin
      if (c == drop_c) begin bus.Rd = 1'b0; bus.Wr = 1'b0; end
      if (c == rst_c) rst = 1'b1;
      vio = (bus.Rd && bus.Wr) || (c > 0 && !(bus.Rd || bus.Wr));
      @(negedge clk);
      chk({tag, "_err"}, bus.err, 16'(err_m));
      if (c == rst_c) begin
        chk({tag, "_rst_nodone"}, bus.Done, 16'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        idle_inputs();
        return;
      end
      if (c < MISS_LAT) begin
        chk({tag, "_miss_stall"}, bus.Stall, 16'd1);
        chk({tag, "_miss_done"},  bus.Done,  16'd0);
      end else begin
        chk({tag, "_fill_done"},  bus.Done,     16'd1);
        chk({tag, "_fill_hit"},   bus.CacheHit, 16'd0);
        chk({tag, "_fill_stall"}, bus.Stall,    16'd0);
        chk({tag, "_fill_dout"},  bus.DataOut,  expd);
      end
      @(posedge clk); #1;
      if (vio) err_m = 1'b1;
    end
    if (wr) mem_m[w] = d;
    vld_m[line] = 1'b1;
    tag_m[line] = tg;
    idle_inputs();
  endtask

  logic [15:0] pool [6];
  logic [15:0] ra, rdat;
  int          kind;

  initial begin
    pool[0] = 16'h0002; pool[1] = 16'h0012; pool[2] = 16'h0100;
    pool[3] = 16'h0110; pool[4] = 16'h03FE; pool[5] = 16'h0020;
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    do_reset();

    do_req("cold_rd",  16'h0010, 16'h0000, 1'b1, 1'b0, -1, -1);
    do_req("warm_rd",  16'h0010, 16'h0000, 1'b1, 1'b0, -1, -1);
    do_req("miss_wr",  16'h0020, 16'hBEEF, 1'b0, 1'b1, -1, -1);
    do_req("rd_beef",  16'h0020, 16'h0000, 1'b1, 1'b0, -1, -1);
    do_req("fill_02",  16'h0002, 16'h1234, 1'b0, 1'b1, -1, -1);
    do_req("conf_12",  16'h0012, 16'h0000, 1'b1, 1'b0, -1, -1);
    do_req("back_02",  16'h0002, 16'h0000, 1'b1, 1'b0, -1, -1);
    do_req("misalign", 16'h0003, 16'h0000, 1'b1, 1'b0, -1, -1);
    do_req("post_err", 16'h0002, 16'h0000, 1'b1, 1'b0, -1, -1);
    do_req("post_err2",16'h0200, 16'h5555, 1'b0, 1'b1, -1, -1);

    do_reset();
    do_req("drop_rd",  16'h0030, 16'h0000, 1'b1, 1'b0, 2, -1);
    do_req("drop_chk", 16'h0030, 16'h0000, 1'b1, 1'b0, -1, -1);

    do_reset();
    do_req("bothrw",   16'h0044, 16'hA5A5, 1'b1, 1'b1, -1, -1);
    do_req("both_chk", 16'h0044, 16'h0000, 1'b1, 1'b0, -1, -1);

    do_reset();
    do_req("rst_wr",   16'h0040, 16'hCAFE, 1'b0, 1'b1, -1, 2);
    do_req("rst_rd",   16'h0040, 16'h0000, 1'b1, 1'b0, -1, -1);
    do_req("rst_rd2",  16'h0040, 16'h0000, 1'b1, 1'b0, -1, -1);

    do_reset();
    for (int n = 0; n < 120; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 7) ra = pool[$urandom_range(0, 5)] | ($urandom_range(0, 1) ? 16'h0800 : 16'h0000);
      else          ra = 16'($urandom) & 16'hFFFE;
      if ($urandom_range(0, 39) == 0) ra = ra | 16'h0001;
      rdat = 16'($urandom);
      kind = int'($urandom_range(0, 19));
      if (kind < 10)      do_req("rnd_rd", ra, rdat, 1'b1, 1'b0, -1, -1);
      else if (kind < 19) do_req("rnd_wr", ra, rdat, 1'b0, 1'b1, -1, -1);
      else                do_req("rnd_rw", ra, rdat, 1'b1, 1'b1, -1, -1);
    end

    @(negedge clk);
    chk("end_err", bus.err, 16'(err_m));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
